// File: rtl/lcdram_bg_fetcher_if.sv
`default_nettype none
// ============================================================================
//  Module   : lcdram_bg_fetcher_if
//  Purpose  : Bundles the control, VRAM bus and pixel-handshake signals of
//             the background fetcher into one interface.
//  Signals  : I_START, I_LY, I_SCY, I_SCX, I_LCDC  - line-start controls
//             O_LCDRAM_ADDR, O_LCDRAM_WE_L,
//             O_LCDRAM_RE_L                        - VRAM bus strobes/address
//             O_PIX_ROW, O_PIX_VALID, I_PIX_READY  - pixel row handshake
//             O_BUSY, O_DONE                       - status
//  Modports : master - the fetcher; slave - timing controller / consumer side
//  Revision : 1.0 - initial release
// ============================================================================
interface lcdram_bg_fetcher_if;
    logic        I_START;
    logic [7:0]  I_LY;
    logic [7:0]  I_SCY;
    logic [7:0]  I_SCX;
    logic [7:0]  I_LCDC;
    logic [15:0] O_LCDRAM_ADDR;
    logic        O_LCDRAM_WE_L;
    logic        O_LCDRAM_RE_L;
    logic [15:0] O_PIX_ROW;
    logic        O_PIX_VALID;
    logic        I_PIX_READY;
    logic        O_BUSY;
    logic        O_DONE;

    modport master (
        input  I_START, I_LY, I_SCY, I_SCX, I_LCDC, I_PIX_READY,
        output O_LCDRAM_ADDR, O_LCDRAM_WE_L, O_LCDRAM_RE_L,
               O_PIX_ROW, O_PIX_VALID, O_BUSY, O_DONE
    );

    modport slave (
        output I_START, I_LY, I_SCY, I_SCX, I_LCDC, I_PIX_READY,
        input  O_LCDRAM_ADDR, O_LCDRAM_WE_L, O_LCDRAM_RE_L,
               O_PIX_ROW, O_PIX_VALID, O_BUSY, O_DONE
    );
endinterface
`default_nettype wire

// File: rtl/lcdram_bg_fetcher.sv
`default_nettype none
// ============================================================================
//  Module   : lcdram_bg_fetcher
//  Purpose  : Background scanline fetcher. On each start pulse it reads
//             P_TILES tiles from LCD RAM (map byte, tile-data low byte,
//             tile-data high byte) and hands one 8-pixel 2bpp row per tile
//             to the pixel pipeline over a valid/ready handshake.
//  Ports    : I_CLK          - clock, rising edge
//             I_RESET_L      - synchronous active-low reset
//             IO_LCDRAM_DATA - VRAM data bus, never driven by this block
//             bus            - lcdram_bg_fetcher_if.master (controls, VRAM
//                              address/strobes, pixel handshake, status)
//  Revision : 1.0 - initial release
// ============================================================================
module lcdram_bg_fetcher #(
    parameter int P_RD_CYCLES = 2,   // RE_L low cycles per read, 2..15
    parameter int P_TILES     = 21   // tiles per line, 1..32
) (
    input  wire                 I_CLK,
    input  wire                 I_RESET_L,
    inout  wire  [7:0]          IO_LCDRAM_DATA,
    lcdram_bg_fetcher_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_MAP = 3'd1,
        S_RD_LO  = 3'd2,
        S_RD_HI  = 3'd3,
        S_PUSH   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [3:0] C_RD_LAST   = 4'(P_RD_CYCLES);
    localparam logic [4:0] C_LAST_TILE = 5'(P_TILES - 1);

    state_t      state_q,    state_d;
    logic [4:0]  n_q,        n_d;
    logic [3:0]  cyc_q,      cyc_d;
    logic [7:0]  y_q,        y_d;
    logic [4:0]  scx_col_q,  scx_col_d;
    logic        map_sel_q,  map_sel_d;
    logic        data_sel_q, data_sel_d;
    logic [7:0]  lo_q,       lo_d;
    logic [15:0] addr_q,     addr_d;
    logic        re_l_q,     re_l_d;
    logic [15:0] row_q,      row_d;
    logic        valid_q,    valid_d;
    logic        busy_q,     busy_d;
    logic        done_q,     done_d;

    logic [7:0]  w_start_y;
    logic        w_rd_last;
    logic        w_unused_inputs;

    // Read-only initiator: the data lines are only ever sampled.
    assign IO_LCDRAM_DATA = 8'hzz;

    assign w_start_y       = bus.I_LY + bus.I_SCY;
    assign w_rd_last       = (cyc_q == C_RD_LAST);
    assign w_unused_inputs = ^{bus.I_LCDC[7:5], bus.I_LCDC[2:0], bus.I_SCX[2:0]};

    // Map entry: row y[7:3] of the 32x32 map, column wraps at 32 via the
    // 5-bit sum.
    function automatic logic [15:0] f_map_addr(
        input logic [7:0] y,
        input logic [4:0] scx_col,
        input logic       map_sel,
        input logic [4:0] n
    );
        logic [4:0] col;
        col = scx_col + n;
        f_map_addr = (map_sel ? 16'h9C00 : 16'h9800) + {6'd0, y[7:3], col};
    endfunction

    // Tile-data low byte; the 9000h mode treats the tile index as signed.
    function automatic logic [15:0] f_lo_addr(
        input logic [7:0] tile,
        input logic [7:0] y,
        input logic       data_sel
    );
        if (data_sel) begin
            f_lo_addr = {4'h8, tile, y[2:0], 1'b0};
        end else begin
            f_lo_addr = 16'h9000 + {{4{tile[7]}}, tile, 4'h0}
                                 + {12'h000, y[2:0], 1'b0};
        end
    endfunction

    // Pixel k takes bit k of each plane; bit 7 lands in [15:14] (leftmost).
    function automatic logic [15:0] f_interleave(
        input logic [7:0] hi,
        input logic [7:0] lo
    );
        logic [15:0] row;
        row = 16'h0000;
        for (int k = 0; k < 8; k++) begin
            row[2*k +: 2] = {hi[k], lo[k]};
        end
        f_interleave = row;
    endfunction

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        cyc_d      = cyc_q;
        y_d        = y_q;
        scx_col_d  = scx_col_q;
        map_sel_d  = map_sel_q;
        data_sel_d = data_sel_q;
        lo_d       = lo_q;
        addr_d     = addr_q;
        re_l_d     = re_l_q;
        row_d      = row_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                re_l_d = 1'b1;
                if (bus.I_START) begin
                    y_d        = w_start_y;
                    scx_col_d  = bus.I_SCX[7:3];
                    map_sel_d  = bus.I_LCDC[3];
                    data_sel_d = bus.I_LCDC[4];
                    n_d        = 5'd0;
                    cyc_d      = 4'd0;
                    addr_d     = f_map_addr(w_start_y, bus.I_SCX[7:3],
                                            bus.I_LCDC[3], 5'd0);
                    busy_d     = 1'b1;
                    state_d    = S_RD_MAP;
                end
            end

            // Every read state spends cycle 0 with RE_L high (address setup /
            // inter-read gap), then P_RD_CYCLES cycles low; the data bus is
            // captured at the end of the last low cycle.
            S_RD_MAP, S_RD_LO, S_RD_HI: begin
                if (!w_rd_last) begin
                    cyc_d  = cyc_q + 4'd1;
                    re_l_d = 1'b0;
                end else begin
                    cyc_d  = 4'd0;
                    re_l_d = 1'b1;
                    if (state_q == S_RD_MAP) begin
                        addr_d  = f_lo_addr(IO_LCDRAM_DATA, y_q, data_sel_q);
                        state_d = S_RD_LO;
                    end else if (state_q == S_RD_LO) begin
                        lo_d    = IO_LCDRAM_DATA;
                        addr_d  = addr_q + 16'd1;
                        state_d = S_RD_HI;
                    end else begin
                        row_d   = f_interleave(IO_LCDRAM_DATA, lo_q);
                        valid_d = 1'b1;
                        state_d = S_PUSH;
                    end
                end
            end

            S_PUSH: begin
                re_l_d = 1'b1;
                if (bus.I_PIX_READY) begin
                    valid_d = 1'b0;
                    if (n_q == C_LAST_TILE) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        n_d     = n_q + 5'd1;
                        cyc_d   = 4'd0;
                        addr_d  = f_map_addr(y_q, scx_col_q, map_sel_q,
                                             n_q + 5'd1);
                        state_d = S_RD_MAP;
                    end
                end
            end

            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                re_l_d  = 1'b1;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge I_CLK) begin
        if (!I_RESET_L) begin
            state_q    <= S_IDLE;
            n_q        <= 5'd0;
            cyc_q      <= 4'd0;
            y_q        <= 8'h00;
            scx_col_q  <= 5'd0;
            map_sel_q  <= 1'b0;
            data_sel_q <= 1'b0;
            lo_q       <= 8'h00;
            addr_q     <= 16'h0000;
            re_l_q     <= 1'b1;
            row_q      <= 16'h0000;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            cyc_q      <= cyc_d;
            y_q        <= y_d;
            scx_col_q  <= scx_col_d;
            map_sel_q  <= map_sel_d;
            data_sel_q <= data_sel_d;
            lo_q       <= lo_d;
            addr_q     <= addr_d;
            re_l_q     <= re_l_d;
            row_q      <= row_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.O_LCDRAM_ADDR = addr_q;
    assign bus.O_LCDRAM_WE_L = 1'b1;
    assign bus.O_LCDRAM_RE_L = re_l_q;
    assign bus.O_PIX_ROW     = row_q;
    assign bus.O_PIX_VALID   = valid_q;
    assign bus.O_BUSY        = busy_q;
    assign bus.O_DONE        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_lcdram_bg_fetcher.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lcdram_bg_fetcher
//  Purpose  : Self-checking bench for lcdram_bg_fetcher. dut1 uses
//             P_RD_CYCLES=2, dut2 uses P_RD_CYCLES=3; both read a shared
//             8 KB VRAM model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lcdram_bg_fetcher;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lcdram_bg_fetcher_if bus1();
    lcdram_bg_fetcher_if bus2();
    wire [7:0] data1;
    wire [7:0] data2;

    logic [7:0] mem [0:8191];

    assign data1 = bus1.O_LCDRAM_RE_L ? 8'hzz : mem[bus1.O_LCDRAM_ADDR[12:0]];
    assign data2 = bus2.O_LCDRAM_RE_L ? 8'hzz : mem[bus2.O_LCDRAM_ADDR[12:0]];

    lcdram_bg_fetcher #(.P_RD_CYCLES(2), .P_TILES(21)) dut1 (
        .I_CLK(clk), .I_RESET_L(rst_n), .IO_LCDRAM_DATA(data1), .bus(bus1));
    lcdram_bg_fetcher #(.P_RD_CYCLES(3), .P_TILES(21)) dut2 (
        .I_CLK(clk), .I_RESET_L(rst_n), .IO_LCDRAM_DATA(data2), .bus(bus2));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- dut1 monitor (samples mid-cycle) ----------------
    logic [15:0] rd_log[$];
    logic [15:0] row_log[$];
    int          rows1 = 0;
    int          dones1 = 0;

    initial begin
        int          lo_len = 0;
        logic [15:0] lo_addr = 16'h0;
        bit          moved = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                lo_len = 0;
                moved  = 1'b0;
            end else begin
                if (!bus1.O_LCDRAM_RE_L) begin
                    if (lo_len == 0) begin
                        lo_addr = bus1.O_LCDRAM_ADDR;
                        rd_log.push_back(bus1.O_LCDRAM_ADDR);
                        moved = 1'b0;
                    end else if (bus1.O_LCDRAM_ADDR != lo_addr) begin
                        moved = 1'b1;
                    end
                    lo_len++;
                end else if (lo_len != 0) begin
                    chk("re_l low width p2", lo_len, 2);
                    chk("addr stable during read p2", {31'd0, moved}, 0);
                    chk("we_l high p2", {31'd0, bus1.O_LCDRAM_WE_L}, 1);
                    lo_len = 0;
                end
                if (bus1.O_PIX_VALID)
                    chk("no read while row pending", {31'd0, bus1.O_LCDRAM_RE_L}, 1);
                if (bus1.O_PIX_VALID && bus1.I_PIX_READY) begin
                    row_log.push_back(bus1.O_PIX_ROW);
                    rows1++;
                end
                if (bus1.O_DONE) dones1++;
            end
        end
    end

    // ---------------- dut2 monitor ----------------
    int pulses2 = 0;
    int rows2   = 0;
    initial begin
        int          lo_len = 0;
        logic [15:0] lo_addr = 16'h0;
        bit          moved = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                lo_len = 0;
            end else begin
                if (!bus2.O_LCDRAM_RE_L) begin
                    if (lo_len == 0) begin
                        lo_addr = bus2.O_LCDRAM_ADDR;
                        moved   = 1'b0;
                    end else if (bus2.O_LCDRAM_ADDR != lo_addr) begin
                        moved = 1'b1;
                    end
                    lo_len++;
                end else if (lo_len != 0) begin
                    chk("re_l low width p3", lo_len, 3);
                    chk("addr stable during read p3", {31'd0, moved}, 0);
                    chk("we_l high p3", {31'd0, bus2.O_LCDRAM_WE_L}, 1);
                    pulses2++;
                    lo_len = 0;
                end
                if (bus2.O_PIX_VALID && bus2.I_PIX_READY) rows2++;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic start1(input logic [7:0] lcdc, ly, scy, scx);
        @(posedge clk); #1;
        bus1.I_LCDC = lcdc; bus1.I_LY = ly; bus1.I_SCY = scy; bus1.I_SCX = scx;
        bus1.I_START = 1'b1;
        @(posedge clk); #1;
        bus1.I_START = 1'b0;
        // Live inputs change right after the start; the line must not notice.
        bus1.I_LCDC = ~lcdc; bus1.I_LY = ~ly; bus1.I_SCY = ~scy; bus1.I_SCX = ~scx;
        chk("busy after start", {31'd0, bus1.O_BUSY}, 1);
    endtask

    task automatic wait_done1(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (bus1.O_DONE) begin
                seen = 1'b1;
                break;
            end
        end
        chk(name, {31'd0, seen}, 1);
    endtask

    task automatic clear1();
        rd_log.delete();
        row_log.delete();
        rows1  = 0;
        dones1 = 0;
    endtask

    typedef struct {
        logic [7:0]  lcdc, ly, scy, scx;
        logic [7:0]  map_b, lo_b, hi_b;
        logic [15:0] e_map0, e_map1, e_lo, e_hi, e_row;
    } vec_t;

    vec_t vecs [6];

    initial begin
        bit ok;
        logic [15:0] held_row;
        int lows;

        vecs[0] = '{8'h91, 8'h00, 8'h00, 8'h00, 8'h01, 8'hFF, 8'h00,
                    16'h9800, 16'h9801, 16'h8010, 16'h8011, 16'h5555};
        vecs[1] = '{8'h81, 8'h03, 8'h00, 8'h00, 8'h80, 8'h00, 8'hFF,
                    16'h9800, 16'h9801, 16'h8806, 16'h8807, 16'hAAAA};
        vecs[2] = '{8'h81, 8'h01, 8'h02, 8'h10, 8'h7F, 8'hF0, 8'hCC,
                    16'h9802, 16'h9803, 16'h97F6, 16'h97F7, 16'hF5A0};
        vecs[3] = '{8'h99, 8'h05, 8'h10, 8'hF8, 8'h02, 8'hA5, 8'h3C,
                    16'h9C5F, 16'h9C40, 16'h802A, 16'h802B, 16'h4EB1};
        vecs[4] = '{8'h91, 8'h90, 8'h80, 8'h08, 8'hFF, 8'h81, 8'h81,
                    16'h9841, 16'h9842, 16'h8FF0, 16'h8FF1, 16'hC003};
        vecs[5] = '{8'h01, 8'h07, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h00,
                    16'h9800, 16'h9801, 16'h900E, 16'h900F, 16'h0055};

        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        bus1.I_START = 1'b0; bus1.I_LY = 8'h00; bus1.I_SCY = 8'h00;
        bus1.I_SCX = 8'h00;  bus1.I_LCDC = 8'h00; bus1.I_PIX_READY = 1'b1;
        bus2.I_START = 1'b0; bus2.I_LY = 8'h00; bus2.I_SCY = 8'h00;
        bus2.I_SCX = 8'h00;  bus2.I_LCDC = 8'h91; bus2.I_PIX_READY = 1'b1;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        chk("reset addr", {16'd0, bus1.O_LCDRAM_ADDR}, 32'h0000);
        chk("reset strobes re/we", {30'd0, bus1.O_LCDRAM_RE_L, bus1.O_LCDRAM_WE_L}, 32'h3);
        chk("reset row", {16'd0, bus1.O_PIX_ROW}, 32'h0000);
        chk("reset valid/busy/done",
            {29'd0, bus1.O_PIX_VALID, bus1.O_BUSY, bus1.O_DONE}, 32'h0);
        rst_n = 1'b1;

        // ---- table-driven lines ----
        for (int i = 0; i < 6; i++) begin
            mem[vecs[i].e_map0[12:0]] = vecs[i].map_b;
            mem[vecs[i].e_lo[12:0]]   = vecs[i].lo_b;
            mem[vecs[i].e_hi[12:0]]   = vecs[i].hi_b;
            clear1();
            start1(vecs[i].lcdc, vecs[i].ly, vecs[i].scy, vecs[i].scx);
            // A start while busy must be ignored.
            repeat (40) @(posedge clk);
            #1;
            bus1.I_START = 1'b1;
            @(posedge clk); #1;
            bus1.I_START = 1'b0;
            wait_done1($sformatf("v%0d done seen", i));
            repeat (2) @(negedge clk);
            chk($sformatf("v%0d map0 addr", i), {16'd0, rd_log[0]}, {16'd0, vecs[i].e_map0});
            chk($sformatf("v%0d lo addr", i),   {16'd0, rd_log[1]}, {16'd0, vecs[i].e_lo});
            chk($sformatf("v%0d hi addr", i),   {16'd0, rd_log[2]}, {16'd0, vecs[i].e_hi});
            chk($sformatf("v%0d map1 addr", i), {16'd0, rd_log[3]}, {16'd0, vecs[i].e_map1});
            chk($sformatf("v%0d first row", i), {16'd0, row_log[0]}, {16'd0, vecs[i].e_row});
            chk($sformatf("v%0d rows", i), rows1, 21);
            chk($sformatf("v%0d done pulses", i), dones1, 1);
            chk($sformatf("v%0d reads", i), rd_log.size(), 63);
            chk($sformatf("v%0d idle busy", i), {31'd0, bus1.O_BUSY}, 0);
        end

        // ---- backpressure on tile 4, then start during DONE ----
        mem[13'h1804] = 8'h03;
        mem[13'h0030] = 8'h0F;
        mem[13'h0031] = 8'hF0;
        clear1();
        start1(8'h91, 8'h00, 8'h00, 8'h00);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (rows1 == 4) begin ok = 1'b1; break; end
        end
        chk("bp reached tile 4", {31'd0, ok}, 1);
        bus1.I_PIX_READY = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus1.O_PIX_VALID) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        chk("bp row valid", {31'd0, ok}, 1);
        held_row = bus1.O_PIX_ROW;
        chk("bp tile 4 row", {16'd0, held_row}, 32'hAA55);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("bp stall held", {14'd0, bus1.O_PIX_VALID, bus1.O_LCDRAM_RE_L, bus1.O_PIX_ROW},
                {14'd0, 1'b1, 1'b1, held_row});
        end
        bus1.I_PIX_READY = 1'b1;
        @(posedge clk); #1;
        chk("bp accepted", {15'd0, bus1.O_PIX_VALID, bus1.O_LCDRAM_ADDR}, {15'd0, 1'b0, 16'h9805});
        @(posedge clk); #1;
        chk("bp fetch resumes", {31'd0, bus1.O_LCDRAM_RE_L}, 0);
        wait_done1("bp done seen");
        bus1.I_START = 1'b1;            // lands in the DONE cycle
        @(posedge clk); #1;
        bus1.I_START = 1'b0;
        chk("start in done ignored", {31'd0, bus1.O_BUSY}, 0);
        @(posedge clk); #1;
        chk("idle after done", {30'd0, bus1.O_BUSY, bus1.O_LCDRAM_RE_L}, 32'h1);
        chk("bp rows", rows1, 21);
        chk("bp row log tile 4", {16'd0, row_log[4]}, 32'hAA55);

        // ---- strobe timing at P_RD_CYCLES=3 ----
        @(posedge clk); #1;
        bus2.I_START = 1'b1;
        @(posedge clk); #1;
        bus2.I_START = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if (bus2.O_DONE) begin ok = 1'b1; break; end
        end
        chk("p3 done seen", {31'd0, ok}, 1);
        repeat (2) @(negedge clk);
        chk("p3 read pulses", pulses2, 63);
        chk("p3 rows", rows2, 21);

        // ---- reset during RD_LO, then a clean restart ----
        mem[13'h1800] = 8'h01;
        clear1();
        start1(8'h91, 8'h00, 8'h00, 8'h00);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (bus1.O_LCDRAM_ADDR == 16'h8010 && !bus1.O_LCDRAM_RE_L) begin
                ok = 1'b1; break;
            end
        end
        chk("rst reached RD_LO", {31'd0, ok}, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst abort outputs",
            {13'd0, bus1.O_LCDRAM_RE_L, bus1.O_PIX_VALID, bus1.O_BUSY, bus1.O_LCDRAM_ADDR},
            {13'd0, 1'b1, 1'b0, 1'b0, 16'h0000});
        rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (!bus1.O_LCDRAM_RE_L) lows++;
        end
        chk("no reads after reset", lows, 0);
        chk("no row after reset", rows1, 0);
        clear1();
        start1(8'h91, 8'h00, 8'h00, 8'h00);
        wait_done1("restart done seen");
        repeat (2) @(negedge clk);
        chk("restart map0", {16'd0, rd_log[0]}, 32'h9800);
        chk("restart lo", {16'd0, rd_log[1]}, 32'h8010);
        chk("restart first row", {16'd0, row_log[0]}, 32'h5555);
        chk("restart rows", rows1, 21);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
